skewed_edge_feeder: RTL and testbench

//   Parametrised successor to the fixed N x N edge queues: one block drives both the north
//   (weight) and west (data) edges of a ROWS x COLS systolic array from internal buffers.

---
 rtl/skewed_edge_feeder.sv | 210 +++++++++++++++++++++
 tb/tb_skewed_edge_feeder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skewed_edge_feeder.sv
// skewed_edge_feeder
//   Drives the north (weight) and west (data) edges of a ROWS x COLS systolic
//   array from internal per-lane buffers. Lane i is delayed by i cycles, so
//   operands meet on the array diagonal. A pass has four phases: IDLE, FEED,
//   DRAIN (zero inputs while partial sums settle) and DONE (one-cycle pulse).
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   wr_en_i/sel/lane/k   buffer write port (sel 0 = north, 1 = west), IDLE only
//   wr_data_i            write data
//   start_i, k_len_i     start a pass with inner dimension k_len_i (1..MAX_K)
//   stall_i              freeze FEED/DRAIN progress, outputs hold
//   north_o/_valid_o     COLS lanes of edge data and per-lane valid
//   west_o/_valid_o      ROWS lanes of edge data and per-lane valid
//   busy_o               FEED or DRAIN
//   done_o               one-cycle pulse at end of pass
//   err_o                one-cycle pulse for a rejected start or write

// One edge lane: its own buffer plus the registered output stage. The
// lane shows element (t - LANE) of its buffer while that index is inside
// [0, k_len); otherwise it shows zero with valid low.
module skewed_edge_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_K      = 16,
  parameter int LANE       = 0,
  parameter int TW         = 5,
  parameter int KW         = 4,
  parameter int KLW        = 5
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  wr_en_i,
  input  logic [KW-1:0]         wr_k_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  load_i,
  input  logic                  clr_i,
  input  logic [TW-1:0]         t_i,
  input  logic [KLW-1:0]        k_len_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);
  logic [DATA_WIDTH-1:0] mem [MAX_K];
  int                    rel;
  logic                  hit;
  logic [KW-1:0]         idx;
  logic [DATA_WIDTH-1:0] rd;

  always_comb begin
    rel = int'(t_i) - LANE;
    hit = (rel >= 0) && (rel < int'(k_len_i));
    idx = KW'(rel);
    // A write landing on the same edge as the start must already be seen
    // by the first output, so forward it around the buffer.
    rd  = (wr_en_i && (wr_k_i == idx)) ? wr_data_i : mem[idx];
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_k_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (clr_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (load_i) begin
      data_o  <= hit ? rd : '0;
      valid_o <= hit;
    end
  end
endmodule

module skewed_edge_feeder #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_K        = 16,
  parameter int DRAIN_CYCLES = ROWS + COLS,
  localparam int LMAX = (ROWS > COLS) ? ROWS : COLS,
  localparam int LW   = (LMAX > 1) ? $clog2(LMAX) : 1,
  localparam int KW   = (MAX_K > 1) ? $clog2(MAX_K) : 1,
  localparam int KLW  = $clog2(MAX_K + 1),
  localparam int TW   = $clog2(MAX_K + LMAX),
  localparam int DCW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             wr_en_i,
  input  logic                             wr_sel_i,
  input  logic [LW-1:0]                    wr_lane_i,
  input  logic [KW-1:0]                    wr_k_i,
  input  logic [DATA_WIDTH-1:0]            wr_data_i,
  input  logic                             start_i,
  input  logic [KLW-1:0]                   k_len_i,
  input  logic                             stall_i,
  output logic [COLS-1:0][DATA_WIDTH-1:0]  north_o,
  output logic [COLS-1:0]                  north_valid_o,
  output logic [ROWS-1:0][DATA_WIDTH-1:0]  west_o,
  output logic [ROWS-1:0]                  west_valid_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t         state;
  logic [TW-1:0]  t;
  logic [KLW-1:0] k_len_q;
  logic [DCW-1:0] dcnt;

  logic           busy, k_ok, start_ok, wr_bad, wr_ok, err_n;
  logic           feed_adv, feed_last, load, clr;
  logic [TW-1:0]  t_sel;
  logic [KLW-1:0] klen_sel;

  always_comb begin
    busy      = (state == FEED) || (state == DRAIN);
    k_ok      = (k_len_i != '0) && (int'(k_len_i) <= MAX_K);
    start_ok  = (state == IDLE) && start_i && k_ok;
    wr_bad    = (int'(wr_k_i) >= MAX_K) ||
                (int'(wr_lane_i) >= (wr_sel_i ? ROWS : COLS));
    wr_ok     = (state == IDLE) && wr_en_i && !wr_bad;
    err_n     = (busy && (wr_en_i || start_i)) ||
                ((state == IDLE) && ((wr_en_i && wr_bad) || (start_i && !k_ok)));
    feed_adv  = (state == FEED) && !stall_i;
    // Last feed step: the farthest lane has shown its final element.
    feed_last = int'(t) == int'(k_len_q) + LMAX - 2;
    // Lanes register the value for the step about to be shown: t = 0 at
    // start, t + 1 while feeding. Stall simply withholds the load.
    load      = start_ok || (feed_adv && !feed_last);
    clr       = feed_adv && feed_last;
    t_sel     = start_ok ? '0 : t + 1'b1;
    klen_sel  = start_ok ? k_len_i : k_len_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      t       <= '0;
      k_len_q <= '0;
      dcnt    <= '0;
      err_o   <= 1'b0;
    end else begin
      err_o <= err_n;
      case (state)
        IDLE: if (start_ok) begin
          state   <= FEED;
          t       <= '0;
          k_len_q <= k_len_i;
        end
        FEED: if (feed_adv) begin
          if (feed_last) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            t <= t + 1'b1;
          end
        end
        DRAIN: if (!stall_i) begin
          if (int'(dcnt) == DRAIN_CYCLES - 1) state <= DONE;
          else                               dcnt  <= dcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = busy;
  assign done_o = (state == DONE);

  for (genvar i = 0; i < COLS; i++) begin : g_north
    skewed_edge_lane #(
      .DATA_WIDTH(DATA_WIDTH), .MAX_K(MAX_K), .LANE(i),
      .TW(TW), .KW(KW), .KLW(KLW)
    ) u_lane (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .wr_en_i  (wr_ok && !wr_sel_i && (int'(wr_lane_i) == i)),
      .wr_k_i   (wr_k_i),
      .wr_data_i(wr_data_i),
      .load_i   (load),
      .clr_i    (clr),
      .t_i      (t_sel),
      .k_len_i  (klen_sel),
      .data_o   (north_o[i]),
      .valid_o  (north_valid_o[i])
    );
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_west
    skewed_edge_lane #(
      .DATA_WIDTH(DATA_WIDTH), .MAX_K(MAX_K), .LANE(i),
      .TW(TW), .KW(KW), .KLW(KLW)
    ) u_lane (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .wr_en_i  (wr_ok && wr_sel_i && (int'(wr_lane_i) == i)),
      .wr_k_i   (wr_k_i),
      .wr_data_i(wr_data_i),
      .load_i   (load),
      .clr_i    (clr),
      .t_i      (t_sel),
      .k_len_i  (klen_sel),
      .data_o   (west_o[i]),
      .valid_o  (west_valid_o[i])
    );
  end
endmodule

// File: tb/tb_skewed_edge_feeder.sv
// Bench for skewed_edge_feeder: a 4x4 instance (m0) and a 2x5 instance (m1)
// share stimulus; sel gates write/start per instance. A position-based model
// predicts every output each cycle; directed checks pin literal values.
module tb_skewed_edge_feeder;
  localparam int DW = 32;
  localparam int MK = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic clk = 1'b0, rstn = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, stall = 1'b0;
  logic [2:0]    wr_lane = '0;
  logic [3:0]    wr_k = '0;
  logic [DW-1:0] wr_data = '0;
  logic [4:0]    k_len = '0;
  logic [1:0]    sel = 2'b01;

  logic [3:0][DW-1:0] n0, w0;
  logic [3:0]         nv0, wv0;
  logic               busy0, done0, err0;
  logic [4:0][DW-1:0] n1;
  logic [1:0][DW-1:0] w1;
  logic [4:0]         nv1;
  logic [1:0]         wv1;
  logic               busy1, done1, err1;

  skewed_edge_feeder #(.ROWS(4), .COLS(4), .DATA_WIDTH(DW), .MAX_K(MK)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en & sel[0]), .wr_sel_i(wr_sel),
    .wr_lane_i(wr_lane[1:0]), .wr_k_i(wr_k), .wr_data_i(wr_data),
    .start_i(start & sel[0]), .k_len_i(k_len), .stall_i(stall),
    .north_o(n0), .north_valid_o(nv0), .west_o(w0), .west_valid_o(wv0),
    .busy_o(busy0), .done_o(done0), .err_o(err0));

  skewed_edge_feeder #(.ROWS(2), .COLS(5), .DATA_WIDTH(DW), .MAX_K(MK)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en & sel[1]), .wr_sel_i(wr_sel),
    .wr_lane_i(wr_lane), .wr_k_i(wr_k), .wr_data_i(wr_data),
    .start_i(start & sel[1]), .k_len_i(k_len), .stall_i(stall),
    .north_o(n1), .north_valid_o(nv1), .west_o(w1), .west_valid_o(wv1),
    .busy_o(busy1), .done_o(done1), .err_o(err1));

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int done_cnt[2], done_cyc[2], busy_cnt[2];
  int base_done, base_busy;

  function automatic int nrows(input int m); return (m == 0) ? 4 : 2; endfunction
  function automatic int ncols(input int m); return (m == 0) ? 4 : 5; endfunction
  function automatic int lmax(input int m);  return (m == 0) ? 4 : 5; endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one position counter per pass. Positions 0..F-1 are feed steps
  // (F = k + L - 1), the next D = ROWS + COLS are drain, then one DONE cycle.
  logic [DW-1:0] mbuf [2][2][5][16];
  int            mmode[2], mp[2], mk[2];
  logic          merr[2];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int m = 0; m < 2; m++) begin
        mmode[m] <= M_IDLE; mp[m] <= 0; mk[m] <= 0; merr[m] <= 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        merr[m] <= 1'b0;
        case (mmode[m])
          M_IDLE: begin
            if (wr_en && sel[m]) begin
              if (int'(wr_lane) < (wr_sel ? nrows(m) : ncols(m)))
                mbuf[m][wr_sel][wr_lane][wr_k] <= wr_data;
              else
                merr[m] <= 1'b1;
            end
            if (start && sel[m]) begin
              if (k_len >= 1 && int'(k_len) <= MK) begin
                mmode[m] <= M_RUN; mp[m] <= 0; mk[m] <= int'(k_len);
              end else merr[m] <= 1'b1;
            end
          end
          M_RUN: begin
            if ((wr_en || start) && sel[m]) merr[m] <= 1'b1;
            if (!stall) begin
              if (mp[m] == mk[m] + lmax(m) - 1 + nrows(m) + ncols(m) - 1) mmode[m] <= M_DONE;
              else mp[m] <= mp[m] + 1;
            end
          end
          default: mmode[m] <= M_IDLE;
        endcase
      end
    end
  end

  function automatic logic [DW:0] exp_lane(input int m, input int s, input int j);
    int q;
    q = mp[m] - j;
    if (mmode[m] == M_RUN && q >= 0 && q < mk[m]) return {1'b1, mbuf[m][s][j][q]};
    return '0;
  endfunction

  logic [DW:0] act_n[2][5], act_w[2][5];
  logic [2:0]  act_c[2];
  always_comb begin
    for (int m = 0; m < 2; m++)
      for (int j = 0; j < 5; j++) begin act_n[m][j] = '0; act_w[m][j] = '0; end
    for (int j = 0; j < 4; j++) begin act_n[0][j] = {nv0[j], n0[j]}; act_w[0][j] = {wv0[j], w0[j]}; end
    for (int j = 0; j < 5; j++) act_n[1][j] = {nv1[j], n1[j]};
    for (int j = 0; j < 2; j++) act_w[1][j] = {wv1[j], w1[j]};
    act_c[0] = {busy0, done0, err0};
    act_c[1] = {busy1, done1, err1};
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < ncols(m); j++)
        chk($sformatf("m%0d_north%0d", m, j), 64'(act_n[m][j]), 64'(exp_lane(m, 0, j)));
      for (int j = 0; j < nrows(m); j++)
        chk($sformatf("m%0d_west%0d", m, j), 64'(act_w[m][j]), 64'(exp_lane(m, 1, j)));
      chk($sformatf("m%0d_busy_done_err", m), 64'(act_c[m]),
          64'({mmode[m] == M_RUN, mmode[m] == M_DONE, merr[m]}));
      if (act_c[m][1]) begin done_cnt[m] <= done_cnt[m] + 1; done_cyc[m] <= cyc; end
      if (act_c[m][2]) busy_cnt[m] <= busy_cnt[m] + 1;
    end
  end

  task automatic wr(input logic [1:0] s, input bit sl, input int lane, input int k,
                    input logic [DW-1:0] d);
    sel = s; wr_en = 1'b1; wr_sel = sl; wr_lane = 3'(lane); wr_k = 4'(k); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [1:0] s, input int k, output int c);
    int m;
    m = s[1] ? 1 : 0;
    base_done = done_cnt[m]; base_busy = busy_cnt[m];
    sel = s; start = 1'b1; k_len = 5'(k); c = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic finish_pass(input int m, input int c, input int lat, input int blen);
    for (int i = 0; i < 300 && done_cnt[m] == base_done; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk($sformatf("m%0d_done_pulses", m), 64'(done_cnt[m] - base_done), 64'd1);
    chk($sformatf("m%0d_done_cycle", m), 64'(done_cyc[m] - c), 64'(lat));
    chk($sformatf("m%0d_busy_cycles", m), 64'(busy_cnt[m] - base_busy), 64'(blen));
  endtask

  initial begin
    int c;
    for (int m = 0; m < 2; m++) begin done_cnt[m] = 0; done_cyc[m] = 0; busy_cnt[m] = 0; end
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", 64'({busy0, done0, err0}), 64'd0);
    chk("reset_valids", 64'({nv0, wv0}), 64'd0);
    chk("reset_data", 64'(n0[0] | w0[3]), 64'd0);
    @(negedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        wr(2'b01, 1'b0, i, k, DW'(16 * i + k));
        wr(2'b01, 1'b1, i, k, DW'(32'h80 + 16 * i + k));
      end

    // Plain K=4 pass.
    go(2'b01, 4, c);
    wait_cyc(c + 2); chk("A_lane2_pre", 64'(nv0[2]), 64'd0);
    wait_cyc(c + 3); chk("A_lane2_first", 64'({nv0[2], n0[2]}), {31'd0, 1'b1, 32'd32});
                     chk("A_lane0_mid", 64'(n0[0]), 64'd2);
    wait_cyc(c + 6); chk("A_lane2_last", 64'({nv0[2], n0[2]}), {31'd0, 1'b1, 32'd35});
                     chk("A_lane0_gone", 64'(nv0[0]), 64'd0);
    wait_cyc(c + 7); chk("A_valids_tail", 64'(nv0), 64'b1000);
                     chk("A_lane3_last", 64'(n0[3]), 64'd51);
    wait_cyc(c + 8); chk("A_drain", 64'({busy0, nv0, wv0}), 64'h100);
    finish_pass(0, c, 16, 15);

    // Three stall cycles mid-feed.
    go(2'b01, 4, c);
    wait_cyc(c + 3); stall = 1'b1;
    wait_cyc(c + 4); chk("B_frozen1", 64'({nv0[2], n0[2]}), {31'd0, 1'b1, 32'd32});
    wait_cyc(c + 6); chk("B_frozen3", 64'({nv0[2], n0[2]}), {31'd0, 1'b1, 32'd32});
    stall = 1'b0;
    wait_cyc(c + 7); chk("B_resume", 64'(n0[2]), 64'd33);
    finish_pass(0, c, 19, 18);

    // Illegal k_len at start.
    go(2'b01, 0, c);
    chk("k0_err", 64'({err0, busy0, nv0}), 64'h20);
    @(negedge clk); chk("k0_err_clear", 64'({err0, busy0}), 64'd0);
    go(2'b01, 17, c);
    chk("k17_err", 64'({err0, busy0, nv0}), 64'h20);
    @(negedge clk);

    // Start and write while feeding: rejected, stream unchanged.
    go(2'b01, 4, c);
    wait_cyc(c + 2); start = 1'b1; k_len = 5'd4;
    @(negedge clk);  start = 1'b0;
    chk("C_start_busy_err", 64'(err0), 64'd1);
    wait_cyc(c + 4); wr(2'b01, 1'b0, 3, 3, 32'hDEAD);
    chk("C_wr_busy_err", 64'(err0), 64'd1);
    wait_cyc(c + 7); chk("C_lane3_intact", 64'(n0[3]), 64'd51);
    finish_pass(0, c, 16, 15);

    // Reset in DRAIN, then a pass whose start coincides with a write.
    go(2'b01, 4, c);
    wait_cyc(c + 10);
    #2 rstn = 1'b0;
    #1 chk("rst_drain_busy", 64'({busy0, done0, nv0, wv0}), 64'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    base_done = done_cnt[0]; base_busy = busy_cnt[0];
    sel = 2'b01; wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 3'd0; wr_k = 4'd0;
    wr_data = 32'h55; start = 1'b1; k_len = 5'd4; c = cyc;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    chk("D_fwd_write", 64'({nv0[0], n0[0]}), {31'd0, 1'b1, 32'h55});
    finish_pass(0, c, 16, 15);

    // 2x5 instance, K=1.
    for (int j = 0; j < 5; j++) wr(2'b10, 1'b0, j, 0, DW'(32'h200 + j));
    for (int j = 0; j < 2; j++) wr(2'b10, 1'b1, j, 0, DW'(32'h300 + j));
    wr(2'b10, 1'b1, 2, 0, 32'h999);
    chk("E_bad_west_lane", 64'(err1), 64'd1);
    wr(2'b10, 1'b0, 5, 0, 32'h999);
    chk("E_bad_north_lane", 64'(err1), 64'd1);
    go(2'b10, 1, c);
    wait_cyc(c + 2); chk("E_west_t1", 64'(wv1), 64'b10);
                     chk("E_north_t1", 64'(nv1), 64'b00010);
    wait_cyc(c + 5); chk("E_north_t4", 64'({wv1, nv1}), 64'b0010000);
                     chk("E_north4_data", 64'(n1[4]), 64'h204);
    finish_pass(1, c, 13, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
